// File: rtl/mx_int8_block_streamer_if.sv
// Block handshake bus for the MXINT8 streamer: one whole block
// (shared scale + packed elements) offered under valid/ready.
interface mx_int8_block_streamer_if #(
    parameter int BLOCK_SIZE    = 32,
    parameter int ELEMENT_WIDTH = 8,
    parameter int SCALE_WIDTH   = 8
);
    logic                                in_valid_i;
    logic                                in_ready_o;
    logic [SCALE_WIDTH-1:0]              in_scale_i;
    logic [BLOCK_SIZE*ELEMENT_WIDTH-1:0] in_elems_i;

    // Block producer side
    modport master (
        output in_valid_i,
        output in_scale_i,
        output in_elems_i,
        input  in_ready_o
    );

    // Streamer side
    modport slave (
        input  in_valid_i,
        input  in_scale_i,
        input  in_elems_i,
        output in_ready_o
    );
endinterface

// File: rtl/mx_int8_block_streamer.sv
// MXINT8 block streamer: captures one block (scale + BLOCK_SIZE elements)
// on accept, then emits one element per clock with a data_ready pulse on
// element 0 and last_o on the final element. Zero-gap back-to-back blocks
// are supported by accepting during the last element.
module mx_int8_block_streamer #(
    parameter int BLOCK_SIZE    = 32,
    parameter int ELEMENT_WIDTH = 8,
    parameter int SCALE_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mx_int8_block_streamer_if.slave       in_if,
    output logic                          data_ready_o,
    output logic                          elem_valid_o,
    output logic [ELEMENT_WIDTH-1:0]      elem_o,
    output logic [$clog2(BLOCK_SIZE)-1:0] elem_idx_o,
    output logic                          last_o,
    output logic [SCALE_WIDTH-1:0]        scale_o
);
    localparam int IDX_W = $clog2(BLOCK_SIZE);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                                  state;
    logic [BLOCK_SIZE-1:0][ELEMENT_WIDTH-1:0] buf_q;
    logic [IDX_W-1:0]                        idx_nxt;
    logic                                    accept;

    // Ready while idle or while the final element is on the output, so a
    // waiting block follows with no bubble. Held low during reset.
    assign in_if.in_ready_o = rst_n && ((state == IDLE) || (state == STREAM && last_o));
    assign accept           = in_if.in_valid_i && in_if.in_ready_o;
    assign idx_nxt          = elem_idx_o + 1'b1;

    // FSM plus registered output stage; element 0 is driven straight from
    // the input bus on accept so it appears the cycle after capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            buf_q        <= '0;
            data_ready_o <= 1'b0;
            elem_valid_o <= 1'b0;
            elem_o       <= '0;
            elem_idx_o   <= '0;
            last_o       <= 1'b0;
            scale_o      <= '0;
        end else if (accept) begin
            state        <= STREAM;
            buf_q        <= in_if.in_elems_i;
            scale_o      <= in_if.in_scale_i;
            data_ready_o <= 1'b1;
            elem_valid_o <= 1'b1;
            elem_o       <= in_if.in_elems_i[ELEMENT_WIDTH-1:0];
            elem_idx_o   <= '0;
            last_o       <= 1'b0;
        end else if (state == STREAM && !last_o) begin
            data_ready_o <= 1'b0;
            elem_o       <= buf_q[idx_nxt];
            elem_idx_o   <= idx_nxt;
            last_o       <= (idx_nxt == IDX_W'(BLOCK_SIZE - 1));
        end else if (state == STREAM) begin
            // Last element done and nothing waiting: drop to idle, scale held
            state        <= IDLE;
            data_ready_o <= 1'b0;
            elem_valid_o <= 1'b0;
            elem_o       <= '0;
            elem_idx_o   <= '0;
            last_o       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mx_int8_block_streamer.sv
// Bench for mx_int8_block_streamer: randomized and directed blocks into a
// 32-element instance checked by a queue scoreboard, plus a directed
// back-to-back check on a 2-element instance.
module tb_mx_int8_block_streamer;
    localparam int BS = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 32-element instance ----------------
    mx_int8_block_streamer_if #(.BLOCK_SIZE(BS)) bif ();
    logic       data_ready, elem_valid, last;
    logic [7:0] elem, scale;
    logic [4:0] elem_idx;

    mx_int8_block_streamer #(.BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n), .in_if(bif),
        .data_ready_o(data_ready), .elem_valid_o(elem_valid), .elem_o(elem),
        .elem_idx_o(elem_idx), .last_o(last), .scale_o(scale)
    );

    // ---------------- 2-element instance ----------------
    mx_int8_block_streamer_if #(.BLOCK_SIZE(2)) bif2 ();
    logic       data_ready2, elem_valid2, last2;
    logic [7:0] elem2, scale2;
    logic [0:0] elem_idx2;

    mx_int8_block_streamer #(.BLOCK_SIZE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_if(bif2),
        .data_ready_o(data_ready2), .elem_valid_o(elem_valid2), .elem_o(elem2),
        .elem_idx_o(elem_idx2), .last_o(last2), .scale_o(scale2)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [7:0] e;
        int         idx;
        bit         lst;
        bit         dr;
        logic [7:0] sc;
        real        val;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    bit         exp_rdy;
    logic [7:0] last_sc = 8'h00;

    function automatic real decode(input logic [7:0] v);
        int s;
        s = (v >= 8'd128) ? int'(v) - 256 : int'(v);
        return real'(s) / 64.0;
    endfunction

    // Outputs are stable at the falling edge; compare the element due now,
    // then (if the model says the block is taken) queue the next block.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_sc = 8'h00;
            check("rst_ready", bif.in_ready_o, 0);
            check("rst_valid", elem_valid, 0);
            check("rst_elem", elem, 0);
            check("rst_dr", data_ready, 0);
            check("rst_scale", scale, 0);
        end else begin
            if (q.size() == 0) begin
                exp_rdy = 1'b1;
                check("idle_valid", elem_valid, 0);
                check("idle_elem", elem, 0);
                check("idle_idx", elem_idx, 0);
                check("idle_last", last, 0);
                check("idle_dr", data_ready, 0);
                check("idle_scale", scale, last_sc);
            end else begin
                cur     = q.pop_front();
                exp_rdy = cur.lst;
                last_sc = cur.sc;
                check("valid", elem_valid, 1);
                check("elem", elem, cur.e);
                check("idx", elem_idx, cur.idx);
                check("last", last, cur.lst);
                check("data_ready", data_ready, cur.dr);
                check("scale", scale, cur.sc);
                checks++;
                if (decode(elem) != cur.val) begin
                    errors++;
                    $display("FAIL decode: got %f expected %f", decode(elem), cur.val);
                end
            end
            check("in_ready", bif.in_ready_o, exp_rdy);
            if (bif.in_valid_i && exp_rdy) begin
                for (int i = 0; i < BS; i++) begin
                    exp_t x;
                    x.e   = bif.in_elems_i[i*8 +: 8];
                    x.idx = i;
                    x.lst = (i == BS - 1);
                    x.dr  = (i == 0);
                    x.sc  = bif.in_scale_i;
                    x.val = decode(x.e);
                    q.push_back(x);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_block(input logic [7:0] sc, input logic [BS*8-1:0] el);
        bit ok;
        ok = 1'b0;
        bif.in_valid_i = 1'b1;
        bif.in_scale_i = sc;
        bif.in_elems_i = el;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bif.in_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        bif.in_valid_i = 1'b0;
        // Bus content after capture must not matter
        bif.in_elems_i = {8{$urandom}};
        bif.in_scale_i = 8'($urandom);
    endtask

    function automatic logic [BS*8-1:0] rand_block();
        logic [BS*8-1:0] v;
        for (int i = 0; i < BS; i++) v[i*8 +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [BS*8-1:0] blk;

    initial begin
        bif.in_valid_i  = 1'b0;
        bif.in_scale_i  = '0;
        bif.in_elems_i  = '0;
        bif2.in_valid_i = 1'b0;
        bif2.in_scale_i = '0;
        bif2.in_elems_i = '0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);

        // Ramp block, scale 7F
        for (int i = 0; i < BS; i++) blk[i*8 +: 8] = 8'(i);
        send_block(8'h7F, blk);
        wait_cycles(40);

        // Boundary values in fixed-point
        blk = rand_block();
        blk[39:0] = {8'h40, 8'hFF, 8'h00, 8'h7F, 8'h80};
        send_block(8'h05, blk);
        wait_cycles(36);

        // Back-to-back: second block waits with valid high
        send_block(8'h33, rand_block());
        send_block(8'h80, rand_block());
        wait_cycles(36);

        // Held-off offers with changing data during the stream
        send_block(8'h21, rand_block());
        wait_cycles(3);
        for (int k = 0; k < 8; k++) begin
            bif.in_valid_i = 1'b1;
            bif.in_scale_i = 8'($urandom);
            bif.in_elems_i = rand_block();
            wait_cycles(1);
        end
        send_block(8'hC4, rand_block());
        wait_cycles(36);

        // Reset in the middle of a stream
        send_block(8'h9A, rand_block());
        wait_cycles(5);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", elem_valid, 0);
        check("midrst_elem", elem, 0);
        check("midrst_idx", elem_idx, 0);
        check("midrst_last", last, 0);
        check("midrst_dr", data_ready, 0);
        check("midrst_scale", scale, 0);
        check("midrst_ready", bif.in_ready_o, 0);
        wait_cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bif.in_ready_o, 1);
        check("post_rst_valid", elem_valid, 0);
        wait_cycles(1);

        // Randomized traffic with random idle gaps
        for (int b = 0; b < 12; b++) begin
            send_block(8'($urandom), rand_block());
            wait_cycles($urandom_range(0, 40));
        end
        wait_cycles(40);
        check("queue_drained", q.size(), 0);

        // 2-element instance: two blocks back-to-back
        bif2.in_valid_i = 1'b1;
        bif2.in_scale_i = 8'h11;
        bif2.in_elems_i = {8'hB2, 8'hA1};
        begin
            bit ok2;
            ok2 = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (bif2.in_ready_o) begin
                    ok2 = 1'b1;
                    break;
                end
            end
            check("bs2_accept_timeout", ok2, 1);
        end
        @(posedge clk);
        #1;
        bif2.in_scale_i = 8'h22;
        bif2.in_elems_i = {8'hD4, 8'hC3};
        @(negedge clk);
        check("bs2_c0", {data_ready2, last2, elem2, elem_idx2}, {1'b1, 1'b0, 8'hA1, 1'b0});
        check("bs2_c0_scale", scale2, 8'h11);
        @(negedge clk);
        check("bs2_c1", {data_ready2, last2, elem2, elem_idx2}, {1'b0, 1'b1, 8'hB2, 1'b1});
        check("bs2_c1_ready", bif2.in_ready_o, 1);
        @(posedge clk);
        #1;
        bif2.in_valid_i = 1'b0;
        @(negedge clk);
        check("bs2_c2", {data_ready2, last2, elem2, elem_idx2}, {1'b1, 1'b0, 8'hC3, 1'b0});
        check("bs2_c2_scale", scale2, 8'h22);
        @(negedge clk);
        check("bs2_c3", {data_ready2, last2, elem2, elem_idx2}, {1'b0, 1'b1, 8'hD4, 1'b1});
        @(negedge clk);
        check("bs2_idle", {elem_valid2, data_ready2, last2, elem2}, 11'h0);
        check("bs2_idle_scale", scale2, 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
